// File: rtl/eu_operand_fetcher_pkg.sv
// Shared exec-unit datatypes plus the operand fetcher's state and latched-instruction types.
package eu_operand_fetcher_pkg;
    localparam int ADDR_W        = 6;
    localparam int DATA_W        = 16;
    localparam int OPFETCH_OPC_W = 4;

    typedef logic [ADDR_W-1:0] type_alu_local_addr;
    typedef logic [DATA_W-1:0] type_exec_unit_data;

    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} type_opfetch_state;

    typedef struct packed {
        type_alu_local_addr         op0_addr;
        type_alu_local_addr         op1_addr;
        type_alu_local_addr         dst_addr;
        logic [OPFETCH_OPC_W-1:0]   opcode;
    } type_opfetch_instr;
endpackage

// File: rtl/eu_operand_fetcher_if.sv
// Y-buffer operand read / result store bundle; master is the fetcher, slave is the y-buffer.
interface eu_operand_fetcher_if;
    import eu_operand_fetcher_pkg::*;

    type_alu_local_addr op0_req_addr_o;
    type_alu_local_addr op1_req_addr_o;
    logic               op0_req_addr_valid_o;
    logic               op1_req_addr_valid_o;
    type_exec_unit_data op0_data_i;
    type_exec_unit_data op1_data_i;
    logic               op0_data_success_i;
    logic               op1_data_success_i;
    type_alu_local_addr result_addr_o;
    type_exec_unit_data result_data_o;
    logic               result_valid_o;
    logic               result_success_i;

    modport master (
        output op0_req_addr_o, op1_req_addr_o, op0_req_addr_valid_o, op1_req_addr_valid_o,
        output result_addr_o, result_data_o, result_valid_o,
        input  op0_data_i, op1_data_i, op0_data_success_i, op1_data_success_i,
        input  result_success_i
    );

    modport slave (
        input  op0_req_addr_o, op1_req_addr_o, op0_req_addr_valid_o, op1_req_addr_valid_o,
        input  result_addr_o, result_data_o, result_valid_o,
        output op0_data_i, op1_data_i, op0_data_success_i, op1_data_success_i,
        output result_success_i
    );
endinterface

// File: rtl/eu_operand_fetcher_port.sv
// One operand read channel: pending flag, registered request for the 1-cycle response, data latch.
module eu_operand_port
    import eu_operand_fetcher_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic               fetching,
    input  type_exec_unit_data data_i,
    input  logic               success_i,
    output logic               req_valid_o,
    output logic               pend_o,
    output logic               hit_o,
    output type_exec_unit_data data_o
);
    logic               pend_q;
    logic               req_q;
    type_exec_unit_data data_q;

    // A success only counts when it answers last cycle's request; the
    // answered cycle itself already drops the request so it is not re-issued.
    assign hit_o       = fetching & pend_q & req_q & success_i;
    assign req_valid_o = fetching & pend_q & ~(req_q & success_i);
    assign pend_o      = pend_q;
    assign data_o      = data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pend_q <= 1'b0;
            req_q  <= 1'b0;
            data_q <= '0;
        end else begin
            req_q <= req_valid_o;
            if (start) begin
                pend_q <= 1'b1;
                req_q  <= 1'b0;
            end else if (hit_o) begin
                pend_q <= 1'b0;
                data_q <= data_i;
            end
        end
    end
endmodule

// File: rtl/eu_operand_fetcher.sv
// Exec-unit operand fetcher: reads two operands from the y-buffer, hands them to the ALU, stores the result.
module eu_operand_fetcher
    import eu_operand_fetcher_pkg::*;
#(
    parameter int OPC_W       = 4,
    parameter int RETRY_W     = 4,
    parameter int MAX_RETRIES = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               instr_valid_i,
    output logic               instr_ready_o,
    input  type_alu_local_addr instr_op0_addr_i,
    input  type_alu_local_addr instr_op1_addr_i,
    input  type_alu_local_addr instr_dst_addr_i,
    input  logic [OPC_W-1:0]   instr_opcode_i,
    output logic               alu_valid_o,
    output logic [OPC_W-1:0]   alu_opcode_o,
    output type_exec_unit_data alu_a_o,
    output type_exec_unit_data alu_b_o,
    input  type_exec_unit_data alu_result_i,
    input  logic               alu_result_valid_i,
    output logic               fetch_timeout_o,
    output logic               busy_o,
    eu_operand_fetcher_if.master ybuf
);
    type_opfetch_state  state_q;
    type_opfetch_instr  instr_q;
    type_exec_unit_data result_q;
    logic [RETRY_W-1:0] retry_q;
    logic               timeout_q;

    logic start, fetching, fetch_done;
    logic pend0, pend1, hit0, hit1;

    assign start    = (state_q == IDLE) & instr_valid_i;
    assign fetching = (state_q == FETCH);

    eu_operand_port u_port0 (
        .clk(clk), .reset_n(reset_n), .start(start), .fetching(fetching),
        .data_i(ybuf.op0_data_i), .success_i(ybuf.op0_data_success_i),
        .req_valid_o(ybuf.op0_req_addr_valid_o), .pend_o(pend0), .hit_o(hit0), .data_o(alu_a_o)
    );

    eu_operand_port u_port1 (
        .clk(clk), .reset_n(reset_n), .start(start), .fetching(fetching),
        .data_i(ybuf.op1_data_i), .success_i(ybuf.op1_data_success_i),
        .req_valid_o(ybuf.op1_req_addr_valid_o), .pend_o(pend1), .hit_o(hit1), .data_o(alu_b_o)
    );

    // Both operands settled this cycle, whether earlier or right now.
    assign fetch_done = fetching & (~pend0 | hit0) & (~pend1 | hit1);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            result_q  <= '0;
            retry_q   <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid_i) begin
                        instr_q <= '{op0_addr: instr_op0_addr_i, op1_addr: instr_op1_addr_i,
                                     dst_addr: instr_dst_addr_i, opcode: instr_opcode_i};
                        retry_q <= '0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    if (fetch_done) begin
                        state_q <= EXEC;
                    end else if (retry_q == RETRY_W'(MAX_RETRIES - 1)) begin
                        // Timeout is only reported; the fetch keeps retrying.
                        timeout_q <= 1'b1;
                        retry_q   <= '0;
                    end else begin
                        retry_q <= retry_q + 1'b1;
                    end
                end
                EXEC: begin
                    if (alu_result_valid_i) begin
                        result_q <= alu_result_i;
                        state_q  <= WB;
                    end
                end
                WB: begin
                    if (ybuf.result_success_i) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign instr_ready_o       = (state_q == IDLE);
    assign busy_o              = (state_q != IDLE);
    assign alu_valid_o         = (state_q == EXEC);
    assign alu_opcode_o        = instr_q.opcode;
    assign fetch_timeout_o     = timeout_q;
    assign ybuf.op0_req_addr_o = instr_q.op0_addr;
    assign ybuf.op1_req_addr_o = instr_q.op1_addr;
    assign ybuf.result_valid_o = (state_q == WB);
    assign ybuf.result_addr_o  = instr_q.dst_addr;
    assign ybuf.result_data_o  = result_q;
endmodule

// File: tb/tb_eu_operand_fetcher.sv
// Bench for eu_operand_fetcher: directed vector table, corner sequences and a randomized y-buffer/ALU model.
module tb_eu_operand_fetcher;
    import eu_operand_fetcher_pkg::*;

    localparam int MAXR = 4;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               instr_valid_i;
    logic               instr_ready_o;
    type_alu_local_addr op0a, op1a, dsta;
    logic [3:0]         opc;
    logic               alu_valid_o;
    logic [3:0]         alu_opcode_o;
    type_exec_unit_data alu_a_o, alu_b_o;
    type_exec_unit_data alu_result_i;
    logic               alu_result_valid_i;
    logic               fetch_timeout_o;
    logic               busy_o;

    type_exec_unit_data d0v, d1v, resd;
    int checks = 0;
    int errors = 0;

    eu_operand_fetcher_if ybuf();

    eu_operand_fetcher #(.OPC_W(4), .RETRY_W(4), .MAX_RETRIES(MAXR)) dut (
        .clk(clk), .reset_n(reset_n),
        .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
        .instr_op0_addr_i(op0a), .instr_op1_addr_i(op1a), .instr_dst_addr_i(dsta),
        .instr_opcode_i(opc),
        .alu_valid_o(alu_valid_o), .alu_opcode_o(alu_opcode_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o),
        .alu_result_i(alu_result_i), .alu_result_valid_i(alu_result_valid_i),
        .fetch_timeout_o(fetch_timeout_o), .busy_o(busy_o),
        .ybuf(ybuf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       iv, s0, s1, arv, rs;
        logic [6:0] exp;   // {ready, req0, req1, alu_valid, result_valid, timeout, busy}
    } vec_t;
    vec_t vecs[16];

    function automatic logic [6:0] obs();
        return {instr_ready_o, ybuf.op0_req_addr_valid_o, ybuf.op1_req_addr_valid_o,
                alu_valid_o, ybuf.result_valid_o, fetch_timeout_o, busy_o};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one cycle's inputs and wait to the sampling point of that cycle.
    task automatic drive(input logic iv, input logic s0, input logic s1, input logic arv, input logic rs);
        instr_valid_i           = iv;
        ybuf.op0_data_success_i = s0;
        ybuf.op1_data_success_i = s1;
        ybuf.op0_data_i         = d0v;
        ybuf.op1_data_i         = d1v;
        alu_result_valid_i      = arv;
        alu_result_i            = resd;
        ybuf.result_success_i   = rs;
        @(negedge clk);
    endtask

    task automatic run_random(input int n);
        for (int t = 0; t < n; t++) begin
            logic got0, got1, pr0, pr1, to_exp;
            type_exec_unit_data ea, eb, er;
            int inc, guard, dly, nrej;
            op0a = type_alu_local_addr'($urandom);
            op1a = ($urandom_range(0, 3) == 0) ? op0a : type_alu_local_addr'($urandom);
            dsta = type_alu_local_addr'($urandom);
            opc  = 4'($urandom);
            drive(1, 0, 0, 0, 0);
            chk("rnd_ready", instr_ready_o, 1);
            tick();
            got0 = 0; got1 = 0; pr0 = 0; pr1 = 0; to_exp = 0; inc = 0; guard = 0;
            ea = '0; eb = '0;
            while (!(got0 && got1) && guard < 300) begin
                logic s0, s1, a0, a1, e0, e1;
                s0  = pr0 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
                s1  = pr1 ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 5) == 0);
                d0v = type_exec_unit_data'($urandom);
                d1v = type_exec_unit_data'($urandom);
                a0  = pr0 && s0;
                a1  = pr1 && s1;
                e0  = !got0 && !a0;
                e1  = !got1 && !a1;
                drive(0, s0, s1, 0, 0);
                chk("rnd_req0", ybuf.op0_req_addr_valid_o, e0);
                chk("rnd_req1", ybuf.op1_req_addr_valid_o, e1);
                if (e0) chk("rnd_addr0", ybuf.op0_req_addr_o, op0a);
                if (e1) chk("rnd_addr1", ybuf.op1_req_addr_o, op1a);
                chk("rnd_alu_idle", alu_valid_o, 0);
                chk("rnd_timeout", fetch_timeout_o, to_exp);
                if (a0) begin got0 = 1; ea = d0v; end
                if (a1) begin got1 = 1; eb = d1v; end
                pr0 = e0;
                pr1 = e1;
                to_exp = 0;
                if (!(got0 && got1)) begin
                    inc++;
                    to_exp = (inc % MAXR == 0);
                end
                guard++;
                tick();
            end
            chk("rnd_fetch_bound", guard < 300, 1);
            dly = $urandom_range(0, 3);
            er  = type_exec_unit_data'($urandom);
            for (int k = 0; k <= dly; k++) begin
                resd = (k == dly) ? er : type_exec_unit_data'($urandom);
                drive(0, 0, 0, k == dly, 0);
                chk("rnd_alu_valid", alu_valid_o, 1);
                chk("rnd_alu_ab", {alu_a_o, alu_b_o}, {ea, eb});
                chk("rnd_opcode", alu_opcode_o, opc);
                chk("rnd_exec_timeout", fetch_timeout_o, 0);
                tick();
            end
            nrej = $urandom_range(0, 3);
            for (int k = 0; k <= nrej; k++) begin
                resd = type_exec_unit_data'($urandom);
                drive(0, 0, 0, 0, k == nrej);
                chk("rnd_res_valid", ybuf.result_valid_o, 1);
                chk("rnd_res_addr", ybuf.result_addr_o, dsta);
                chk("rnd_res_data", ybuf.result_data_o, er);
                tick();
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses;
        d0v = 16'hA0A0; d1v = 16'h0B0B; resd = 16'h0055;
        op0a = 6'd1; op1a = 6'd2; dsta = 6'd3; opc = 4'd5;
        vecs[0]  = '{1, 0, 0, 0, 0, 7'b1000000};
        vecs[1]  = '{0, 0, 0, 0, 0, 7'b0110001};
        vecs[2]  = '{0, 1, 1, 0, 0, 7'b0000001};
        vecs[3]  = '{0, 0, 0, 1, 0, 7'b0001001};
        vecs[4]  = '{0, 0, 0, 0, 1, 7'b0000101};
        vecs[5]  = '{0, 0, 0, 0, 0, 7'b1000000};
        vecs[6]  = '{1, 0, 0, 0, 0, 7'b1000000};
        vecs[7]  = '{0, 0, 0, 0, 0, 7'b0110001};
        vecs[8]  = '{0, 1, 0, 0, 0, 7'b0010001};
        vecs[9]  = '{0, 0, 0, 0, 0, 7'b0010001};
        vecs[10] = '{0, 0, 0, 0, 0, 7'b0010001};
        vecs[11] = '{0, 0, 1, 0, 0, 7'b0000011};
        vecs[12] = '{0, 0, 0, 0, 0, 7'b0001001};
        vecs[13] = '{0, 0, 0, 1, 0, 7'b0001001};
        vecs[14] = '{0, 0, 0, 0, 1, 7'b0000101};
        vecs[15] = '{0, 0, 0, 0, 0, 7'b1000000};

        reset_n = 0;
        drive(0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        chk("reset_flags", obs(), 7'b1000000);
        chk("reset_data", {alu_a_o, alu_b_o, ybuf.result_data_o}, 0);
        tick();
        reset_n = 1;

        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].iv, vecs[i].s0, vecs[i].s1, vecs[i].arv, vecs[i].rs);
            chk($sformatf("vec%0d_flags", i), obs(), vecs[i].exp);
            if (vecs[i].exp[5]) chk($sformatf("vec%0d_addr0", i), ybuf.op0_req_addr_o, 1);
            if (vecs[i].exp[4]) chk($sformatf("vec%0d_addr1", i), ybuf.op1_req_addr_o, 2);
            if (vecs[i].exp[3]) chk($sformatf("vec%0d_alu", i), {alu_opcode_o, alu_a_o, alu_b_o}, {4'd5, 16'hA0A0, 16'h0B0B});
            if (vecs[i].exp[2]) chk($sformatf("vec%0d_res", i), {ybuf.result_addr_o, ybuf.result_data_o}, {6'd3, 16'h0055});
            tick();
        end

        // Stale success on op1 in the first fetch cycle must not complete it.
        drive(1, 0, 0, 0, 0); tick();
        d1v = 16'hDEAD;
        drive(0, 0, 1, 0, 0);
        chk("stale_req1", ybuf.op1_req_addr_valid_o, 1);
        tick();
        d0v = 16'h4444; d1v = 16'hBEEF;
        drive(0, 1, 0, 0, 0);
        chk("stale_pend1", {ybuf.op0_req_addr_valid_o, ybuf.op1_req_addr_valid_o}, 2'b01);
        tick();
        d1v = 16'h1234;
        drive(0, 0, 1, 0, 0);
        chk("stale_hit1", {ybuf.op1_req_addr_valid_o, alu_valid_o}, 2'b00);
        tick();
        drive(0, 1, 1, 1, 0);
        chk("stale_alu", {alu_valid_o, alu_a_o, alu_b_o}, {1'b1, 16'h4444, 16'h1234});
        tick();
        drive(0, 0, 0, 0, 1); tick();

        // op0 never answers: timeout pulses every MAXR incomplete cycles, fetch continues.
        pulses = 0;
        d0v = 16'h0F0F; d1v = 16'h00F1;
        drive(1, 0, 0, 0, 0); tick();
        for (int k = 1; k <= 13; k++) begin
            drive(0, 0, k == 2, 0, 0);
            chk($sformatf("to_pulse%0d", k), fetch_timeout_o, (k > 1) && ((k - 1) % MAXR == 0));
            chk($sformatf("to_fetch%0d", k), {ybuf.op0_req_addr_valid_o, alu_valid_o, busy_o}, 3'b101);
            if (fetch_timeout_o) pulses++;
            tick();
        end
        chk("to_pulse_count", pulses, 3);
        drive(0, 1, 0, 0, 0);
        chk("to_done", {fetch_timeout_o, ybuf.op0_req_addr_valid_o}, 2'b00);
        tick();
        drive(0, 0, 0, 1, 0);
        chk("to_alu", {alu_valid_o, alu_a_o, alu_b_o}, {1'b1, 16'h0F0F, 16'h00F1});
        tick();
        drive(0, 0, 0, 0, 1); tick();

        // Store retried twice before acceptance.
        dsta = 6'd9; resd = 16'h7E57;
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0); tick();
        resd = 16'h0000;
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, k == 2);
            chk($sformatf("wb_hold%0d", k), {ybuf.result_valid_o, ybuf.result_addr_o, ybuf.result_data_o},
                {1'b1, 6'd9, 16'h7E57});
            tick();
        end
        drive(0, 0, 0, 0, 0);
        chk("wb_idle", obs(), 7'b1000000);
        tick();

        // Reset in FETCH, then again in WB: instruction discarded, nothing issued afterwards.
        drive(1, 0, 0, 0, 0); tick();
        reset_n = 0;
        drive(0, 0, 0, 0, 0); tick();
        reset_n = 1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 1, 1);
            chk($sformatf("rst_fetch%0d", k), obs(), 7'b1000000);
            tick();
        end
        drive(1, 0, 0, 0, 0); tick();
        drive(0, 0, 0, 0, 0); tick();
        drive(0, 1, 1, 0, 0); tick();
        drive(0, 0, 0, 1, 0); tick();
        reset_n = 0;
        drive(0, 0, 0, 0, 0);
        chk("rst_in_wb", ybuf.result_valid_o, 1);
        tick();
        reset_n = 1;
        for (int k = 0; k < 2; k++) begin
            drive(0, 1, 1, 1, 1);
            chk($sformatf("rst_wb%0d", k), obs(), 7'b1000000);
            tick();
        end

        run_random(40);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/eu_operand_fetcher.md
Name: eu_operand_fetcher

Overview:
- Initiator side of the exec-unit y-buffer operand/result protocol.
- Accepts one decoded instruction at a time and drives op0/op1 read requests to the y-buffer, retrying until each operand reports success.
- Presents both operands to the ALU, then drives the result store into the y-buffer, retrying until it is accepted.
- Sits between the dispatch queue and the ALU inside each exec unit.

Parameters:
OPC_W, 4, width of instr_opcode_i / alu_opcode_o
RETRY_W, 4, width of the fetch retry counter
MAX_RETRIES, 8, FETCH cycles without completion before fetch_timeout_o pulses; must be below 2**RETRY_W

Ports:
clk  in  1  clock
reset_n  in  1  synchronous, active-low reset
instr_valid_i  in  1  instruction offered
instr_ready_o  out  1  fetcher can accept an instruction
instr_op0_addr_i  in  type_alu_local_addr  operand 0 local address
instr_op1_addr_i  in  type_alu_local_addr  operand 1 local address
instr_dst_addr_i  in  type_alu_local_addr  result local address
instr_opcode_i  in  OPC_W  ALU opcode
op0_req_addr_o / op1_req_addr_o  out  type_alu_local_addr  y-buffer request addresses
op0_req_addr_valid_o / op1_req_addr_valid_o  out  1  request valid
op0_data_i / op1_data_i  in  type_exec_unit_data  y-buffer read data
op0_data_success_i / op1_data_success_i  in  1  read hit and not already read
alu_valid_o  out  1  operands presented to ALU
alu_opcode_o  out  OPC_W  latched opcode
alu_a_o / alu_b_o  out  type_exec_unit_data  latched op0 / op1
alu_result_i  in  type_exec_unit_data  ALU result
alu_result_valid_i  in  1  ALU result valid
result_addr_o  out  type_alu_local_addr  store address (latched dst)
result_data_o  out  type_exec_unit_data  store data
result_valid_o  out  1  store request
result_success_i  in  1  store accepted, same cycle
fetch_timeout_o  out  1  one-cycle pulse on retry overflow
busy_o  out  1  state != IDLE

Behaviour:
- Reset (synchronous, active-low, clk rising edge):
  - State goes to IDLE.
  - All outputs reset to 0 except instr_ready_o, which is 1.
  - Internal latches and counter reset to 0.
  - Reset mid-operation discards the instruction; no request or store is issued afterwards.
- FSM states: IDLE, FETCH, EXEC, WB.
- IDLE:
  - instr_ready_o = 1.
  - On instr_valid_i: latch all instr fields, set pend0 = pend1 = 1, clear retry counter, go to FETCH.
- FETCH:
  - opN_req_addr_valid_o = pendN; address = latched opN address.
  - Response latency is fixed at 1 cycle: success/data sampled in cycle N+1 belong to the request valid in cycle N.
  - Track reqN_q = opN_req_addr_valid_o registered.
  - Success with reqN_q=1: latch data, clear pendN; that operand is not requested again.
  - Success with reqN_q=0 is ignored (stale).
  - When both pend bits are clear (including both clearing in the same cycle), go to EXEC next cycle.
  - Retry counter increments every FETCH cycle that does not complete.
  - At MAX_RETRIES: fetch_timeout_o pulses for one cycle, counter clears, fetching continues (no abort).
  - Same address on op0 and op1 is allowed; each port is tracked independently.
- EXEC:
  - alu_valid_o = 1 with latched opcode/a/b.
  - alu_result_valid_i is sampled only in EXEC: latch result, go to WB.
  - alu_valid_o may drop in the cycle after the result.
- WB:
  - result_valid_o = 1, addr = latched dst, data = latched result.
  - result_success_i = 1 goes to IDLE; otherwise hold values stable and retry every cycle.
  - No retry limit in WB.
- Minimum latency, instruction accept (cycle 0) to alu_valid_o: cycle 3; store issued cycle 4 if the ALU returns in the same cycle.
- instr_ready_o is 0 in every state except IDLE; no instruction overlap.

Decomposition:
- pkg_dtypes already holds type_alu_local_addr and type_exec_unit_data.
- Add to pkg_dtypes: typedef enum type_opfetch_state {IDLE, FETCH, EXEC, WB}, and packed struct type_opfetch_instr {op0_addr, op1_addr, dst_addr, opcode}.
- Sub-module eu_operand_port: per-operand pend/req_q/data latch, instantiated twice.

Test Plan:
- Both succeed first try: instr(op0=1, op1=2, dst=3) at cycle 0 -> requests in cycle 1, success in cycle 2, alu_valid_o in cycle 3 with a/b = returned data; ALU returns 0x55 immediately -> result_valid_o cycle 4, addr=3, data=0x55, success -> instr_ready_o cycle 5.
- op0 succeeds in cycle 2, op1 fails 3 times then succeeds -> op0_req_addr_valid_o low from cycle 2, op1 requested through cycle 4, alu_valid_o in cycle 6.
- Stale success (op1_data_success_i=1 with op1 request not valid the previous cycle) -> ignored, pend unchanged.
- Timeout, MAX_RETRIES=4, op0 never succeeds -> fetch_timeout_o pulses once every 4 FETCH cycles, FSM stays in FETCH, requests continue.
- Store retry: result_success_i low for 2 cycles -> result_valid_o/addr/data held stable for 3 cycles, IDLE after the accepting cycle.
- Reset asserted in FETCH and again in WB -> next cycle all valids 0, instr_ready_o=1, busy_o=0.
